alu_dispatch_unit: RTL and testbench
====================================

ALU_DISPATCH_UNIT -- requirements
Module: alu_dispatch_unit

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, meaning mult/div occupancy in cycles (legal 1..255).
REQ-002 SHALL have parameter CTRL_W, default 4, meaning ALU control width (legal >=4; upper bits beyond 4 driven 0).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  decode request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- alu_op_main  in  3  class from main control
- funct  in  6  R-type function field
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts result
- alu_ctrl  out  CTRL_W  ALU operation code
- illegal  out  1  unsupported op/funct
- md_op  out  2  mult/div select: 00 mult, 01 multu, 10 div, 11 divu
- md_start  out  1  one-cycle mult/div launch pulse
- md_busy  out  1  mult/div unit occupied
- md_done  out  1  one-cycle pulse on last busy cycle

Function
REQ-005 alu_op_main map: 000 ADD, 001 SUB, 010 R-type (use funct), 011 AND, 100 OR, 101 XOR, 110 SLT, 111 illegal.
REQ-006 funct map (alu_ctrl): 100000/100001 ADD 0010; 100010/100011 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100110 XOR 1000; 100111 NOR 1001; 101010 SLT 0111; 101011 SLTU 1101; 000100 SLLV 1010; 000110 SRLV 1011; 000111 SRAV 1100; 010000 MFHI 1111; 010010 MFLO 1111.
REQ-007 funct 011000/011001/011010/011011 (MD-class) SHALL produce alu_ctrl NOP 1110, md_op = funct[1:0].
REQ-008 Unmapped funct or alu_op_main 111 SHALL produce alu_ctrl 1110, illegal=1; no X ever driven.
REQ-009 Latency: accepted request appears on out_valid/alu_ctrl/illegal the next cycle (1-entry output register).
REQ-010 Output register SHALL hold all fields stable while out_valid&!out_ready.
REQ-011 in_ready = (!out_valid | out_ready) & !hazard, hazard = md_busy & incoming R-type funct is MD-class, MFHI or MFLO.
REQ-012 in_ready MAY depend combinationally on in_valid-side fields; it SHALL NOT depend on in_valid.
REQ-013 Accepting an MD-class request SHALL assert md_start for exactly one cycle, coincident with its out_valid rise.
REQ-014 md_busy SHALL assert on the md_start cycle and remain high exactly MD_LAT cycles; md_done pulses on the final one.
REQ-015 md_busy counter SHALL be 8 bits, load MD_LAT at acceptance, decrement each cycle, md_busy = (count!=0).
REQ-016 A new MD-class request SHALL NOT be accepted on the md_done cycle; earliest acceptance is the cycle md_busy is low.
REQ-017 Non-hazard ops SHALL flow at one per cycle while md_busy is high.
REQ-018 Illegal requests SHALL be accepted and passed through like any other (no stall, no md_start).
REQ-019 Simultaneous out_ready and new acceptance SHALL replace the output register in the same cycle, no bubble.

Reset
REQ-020 reset SHALL clear out_valid, md_start, md_busy, md_done, illegal to 0; alu_ctrl to 1110; md_op to 00; counter to 0.
REQ-021 reset mid-MD-operation SHALL abort without md_done; in_ready valid (=1) the cycle after reset deasserts.
REQ-022 Requests presented during reset SHALL be discarded.

Verification
REQ-023 alu_op_main=010, funct=100010, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0110, illegal=0.
REQ-024 funct=011010 (div), MD_LAT=4 -> md_start 1 cycle, md_op=10, md_busy 4 cycles, md_done on 4th; MFLO presented meanwhile held off (in_ready=0) until md_busy=0.
REQ-025 out_ready=0 for 3 cycles with funct=100101 held -> alu_ctrl=0001 stable, in_ready=0; releases on out_ready=1.
REQ-026 funct=111111 and alu_op_main=111 -> alu_ctrl=1110, illegal=1, no md_start.
REQ-027 mult accepted, reset asserted 2 cycles later -> md_busy=0, out_valid=0 next cycle, no md_done ever.
REQ-028 Back-to-back ADD,AND,SLTU with out_ready=1 during md_busy -> 3 consecutive out_valid cycles, codes 0010,0000,1101.

Source files
------------

// File: rtl/alu_dispatch_unit.sv
// ALU control decode with a one-entry registered output stage and
// mult/div occupancy tracking that holds off MD-class and HI/LO reads.
module alu_dispatch_unit #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op_main,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic [1:0]        md_op,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_XOR  = 4'b1000;
  localparam logic [3:0] C_NOR  = 4'b1001;
  localparam logic [3:0] C_SLLV = 4'b1010;
  localparam logic [3:0] C_SRLV = 4'b1011;
  localparam logic [3:0] C_SRAV = 4'b1100;
  localparam logic [3:0] C_SLTU = 4'b1101;
  localparam logic [3:0] C_NOP  = 4'b1110;
  localparam logic [3:0] C_HILO = 4'b1111;
  localparam logic [7:0] LAT    = 8'(MD_LAT);

  logic [3:0] dec_ctrl;
  logic       dec_illegal, dec_md, dec_hilo;

  logic       out_valid_q, out_valid_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic       illegal_q, illegal_d;
  logic [1:0] md_op_q, md_op_d;
  logic       md_start_q, md_start_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hazard, accept;

  always_comb begin
    dec_ctrl    = C_NOP;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    dec_hilo    = 1'b0;
    case (alu_op_main)
      3'b000: dec_ctrl = C_ADD;
      3'b001: dec_ctrl = C_SUB;
      3'b011: dec_ctrl = C_AND;
      3'b100: dec_ctrl = C_OR;
      3'b101: dec_ctrl = C_XOR;
      3'b110: dec_ctrl = C_SLT;
      3'b010: begin
        case (funct)
          6'b100000, 6'b100001: dec_ctrl = C_ADD;
          6'b100010, 6'b100011: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b100110: dec_ctrl = C_XOR;
          6'b100111: dec_ctrl = C_NOR;
          6'b101010: dec_ctrl = C_SLT;
          6'b101011: dec_ctrl = C_SLTU;
          6'b000100: dec_ctrl = C_SLLV;
          6'b000110: dec_ctrl = C_SRLV;
          6'b000111: dec_ctrl = C_SRAV;
          6'b010000, 6'b010010: begin
            dec_ctrl = C_HILO;
            dec_hilo = 1'b1;
          end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_md = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // HI/LO reads and new MD ops must wait until the unit is idle, including its done cycle.
  assign hazard   = md_busy & (dec_md | dec_hilo);
  assign in_ready = (~out_valid_q | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    md_op_d     = md_op_q;
    md_start_d  = 1'b0;
    cnt_d       = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    if (accept) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl;
      illegal_d   = dec_illegal;
      if (dec_md) begin
        md_op_d    = funct[1:0];
        md_start_d = 1'b1;
        cnt_d      = LAT;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= C_NOP;
      illegal_q   <= 1'b0;
      md_op_q     <= 2'b00;
      md_start_q  <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      md_op_q     <= md_op_d;
      md_start_q  <= md_start_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctrl  = CTRL_W'(ctrl_q);
  assign illegal   = illegal_q;
  assign md_op     = md_op_q;
  assign md_start  = md_start_q;
  assign md_busy   = (cnt_q != 8'd0);
  assign md_done   = (cnt_q == 8'd1);

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Directed bench for alu_dispatch_unit (MD_LAT=4, CTRL_W=4): inputs change
// 1 ns after the rising edge, registered outputs are checked at that point.
module tb_alu_dispatch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op_main;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic [1:0] md_op;
  logic       md_start, md_busy, md_done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_dispatch_unit #(.MD_LAT(4), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op_main(alu_op_main), .funct(funct), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .md_op(md_op), .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f);
    in_valid    = v;
    alu_op_main = op;
    funct       = f;
  endtask

  logic [2:0] t_op  [16];
  logic [5:0] t_fn  [16];
  logic [3:0] t_exp [16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_op = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd2, 3'd2,
             3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    t_fn = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'b100001, 6'b100011,
             6'b100100, 6'b100110, 6'b100111, 6'b101010, 6'b000100, 6'b000110,
             6'b000111, 6'b010000};
    t_exp = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h8, 4'h7, 4'h2, 4'h6,
              4'h0, 4'h8, 4'h9, 4'h7, 4'hA, 4'hB, 4'hC, 4'hF};

    // Reset with a request pending; it must be discarded.
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd2, 6'b011000);
    cyc(); cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 4'hE);
    chk("rst_illegal", illegal, 0);
    chk("rst_md_op", md_op, 0);
    chk("rst_md_start", md_start, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_md_done", md_done, 0);
    reset = 1'b0;
    drive(1'b0, 3'd0, 6'h00);
    #1 chk("post_rst_in_ready", in_ready, 1);
    cyc();
    chk("rst_req_discarded", out_valid, 0);

    // R-type SUB
    drive(1'b1, 3'd2, 6'b100010);
    cyc();
    drive(1'b0, 3'd0, 6'h00);
    chk("sub_valid", out_valid, 1);
    chk("sub_ctrl", alu_ctrl, 4'h6);
    chk("sub_illegal", illegal, 0);
    cyc();
    chk("drain_valid", out_valid, 0);

    // Illegal funct, then illegal main op: pass through, no md_start
    drive(1'b1, 3'd2, 6'b111111);
    cyc();
    chk("ill_f_ctrl", alu_ctrl, 4'hE);
    chk("ill_f_illegal", illegal, 1);
    chk("ill_f_md_start", md_start, 0);
    chk("ill_f_valid", out_valid, 1);
    drive(1'b1, 3'd7, 6'b100000);
    cyc();
    drive(1'b0, 3'd0, 6'h00);
    chk("ill_op_ctrl", alu_ctrl, 4'hE);
    chk("ill_op_illegal", illegal, 1);
    chk("ill_op_md_start", md_start, 0);
    chk("ill_op_md_busy", md_busy, 0);
    cyc();

    // Full decode table streamed one per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, t_op[i], t_fn[i]);
      cyc();
      chk($sformatf("tbl%0d_ctrl", i), alu_ctrl, t_exp[i]);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_illegal", i), illegal, 0);
    end
    drive(1'b0, 3'd0, 6'h00);
    cyc();

    // Backpressure: OR held with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 6'b100101);
    cyc();
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_ctrl", alu_ctrl, 4'h1);
    #1 chk("bp_first_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("bp%0d_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_ctrl", k), alu_ctrl, 4'h1);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready, 1);
    cyc();
    drive(1'b0, 3'd0, 6'h00);
    chk("bp_replace_valid", out_valid, 1);
    chk("bp_replace_ctrl", alu_ctrl, 4'h1);
    cyc();
    chk("bp_drain_valid", out_valid, 0);

    // DIV, with MFLO held off until the unit is idle
    drive(1'b1, 3'd2, 6'b011010);
    cyc();
    chk("div_start", md_start, 1);
    chk("div_valid", out_valid, 1);
    chk("div_ctrl", alu_ctrl, 4'hE);
    chk("div_md_op", md_op, 2'b10);
    chk("div_busy0", md_busy, 1);
    chk("div_done0", md_done, 0);
    drive(1'b0, 3'd2, 6'b010010);
    #1 chk("mflo_ready_no_valid", in_ready, 0);
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("div_busy%0d", k), md_busy, 1);
      chk($sformatf("div_done%0d", k), md_done, (k == 3) ? 1 : 0);
      chk($sformatf("div_start%0d", k), md_start, 0);
      chk($sformatf("mflo_hold%0d", k), in_ready, 0);
    end
    cyc();
    chk("div_idle_busy", md_busy, 0);
    chk("div_idle_done", md_done, 0);
    chk("mflo_go_in_ready", in_ready, 1);
    cyc();
    drive(1'b0, 3'd0, 6'h00);
    chk("mflo_valid", out_valid, 1);
    chk("mflo_ctrl", alu_ctrl, 4'hF);
    chk("mflo_md_start", md_start, 0);
    cyc();

    // MULT followed by ADD, AND, SLTU flowing during busy
    drive(1'b1, 3'd2, 6'b011000);
    cyc();
    chk("mult_start", md_start, 1);
    chk("mult_md_op", md_op, 2'b00);
    drive(1'b1, 3'd2, 6'b100000);
    #1 chk("add_in_ready_busy", in_ready, 1);
    cyc();
    chk("b2b_add_valid", out_valid, 1);
    chk("b2b_add_ctrl", alu_ctrl, 4'h2);
    chk("b2b_add_busy", md_busy, 1);
    drive(1'b1, 3'd2, 6'b100100);
    cyc();
    chk("b2b_and_valid", out_valid, 1);
    chk("b2b_and_ctrl", alu_ctrl, 4'h0);
    drive(1'b1, 3'd2, 6'b101011);
    cyc();
    drive(1'b0, 3'd0, 6'h00);
    chk("b2b_sltu_valid", out_valid, 1);
    chk("b2b_sltu_ctrl", alu_ctrl, 4'hD);
    chk("b2b_sltu_done", md_done, 1);
    cyc();
    chk("b2b_idle_busy", md_busy, 0);
    chk("b2b_idle_valid", out_valid, 0);

    // MULTU aborted by reset two cycles after acceptance
    drive(1'b1, 3'd2, 6'b011001);
    cyc();
    drive(1'b0, 3'd0, 6'h00);
    chk("abort_start", md_start, 1);
    chk("abort_md_op", md_op, 2'b01);
    cyc();
    chk("abort_busy_pre", md_busy, 1);
    reset = 1'b1;
    drive(1'b1, 3'd2, 6'b100000);
    cyc();
    chk("abort_busy", md_busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", md_done, 0);
    chk("abort_ctrl", alu_ctrl, 4'hE);
    reset = 1'b0;
    drive(1'b0, 3'd0, 6'h00);
    #1 chk("abort_in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("abort_no_done%0d", k), md_done, 0);
      chk($sformatf("abort_no_valid%0d", k), out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
